alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one 4-bit ALU: IDLE -> EXEC -> RESP, round-robin grant.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
// ALU flags: add C=carry, V=signed ovf; sub C=borrow, V=signed ovf; mul C=high nibble nonzero; others C=V=0.

module alu (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  output logic [3:0] q_o,
  output logic       n_o,
  output logic       z_o,
  output logic       v_o,
  output logic       c_o
);
  logic [4:0] sum;
  logic [7:0] prod;

  always_comb begin
    sum  = 5'(a_i) + 5'(b_i);
    prod = 8'(a_i) * 8'(b_i);
    q_o  = 4'd0;
    v_o  = 1'b0;
    c_o  = 1'b0;
    case (s_i)
      4'd0: begin
        q_o = sum[3:0];
        c_o = sum[4];
        v_o = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      4'd1: begin
        q_o = a_i - b_i;
        c_o = (a_i < b_i);
        v_o = (a_i[3] != b_i[3]) && (q_o[3] != a_i[3]);
      end
      4'd2: begin
        q_o = prod[3:0];
        c_o = |prod[7:4];
      end
      4'd3:    q_o = (b_i != 4'd0) ? a_i / b_i : 4'd0;
      4'd4:    q_o = (b_i != 4'd0) ? a_i % b_i : 4'd0;
      4'd5:    q_o = a_i & b_i;
      4'd6:    q_o = a_i | b_i;
      4'd7:    q_o = a_i ^ b_i;
      4'd8:    q_o = a_i << b_i;
      4'd9:    q_o = a_i >> b_i;
      default: q_o = 4'd0;
    endcase
    n_o = q_o[3];
    z_o = (q_o == 4'd0);
  end
endmodule

module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  output logic       req0_ready_o,
  output logic       req1_ready_o,
  input  logic [3:0] req0_a_i,
  input  logic [3:0] req0_b_i,
  input  logic [3:0] req1_a_i,
  input  logic [3:0] req1_b_i,
  input  logic [3:0] req0_op_i,
  input  logic [3:0] req1_op_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [3:0] rsp_q_o,
  output logic [3:0] rsp_flags_o,
  output logic       rsp_err_o,
  output logic [7:0] op_count_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic       id_q, id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_q_q, rsp_q_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] cnt_q, cnt_d;

  logic       any_valid, grant_id, op_err;
  logic [3:0] alu_q;
  logic       alu_n, alu_z, alu_v, alu_c;

  alu u_alu (
    .a_i(a_q), .b_i(b_q), .s_i(op_q),
    .q_o(alu_q), .n_o(alu_n), .z_o(alu_z), .v_o(alu_v), .c_o(alu_c)
  );

  assign any_valid = req0_valid_i | req1_valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_id = ~req0_valid_i;
`else
  assign grant_id = (req0_valid_i & req1_valid_i) ? ~last_grant_q : req1_valid_i;
`endif

  // Ready is gated by rst_n so both stay low while reset is held.
  assign req0_ready_o = rst_n && (state_q == IDLE) && any_valid && !grant_id;
  assign req1_ready_o = rst_n && (state_q == IDLE) && any_valid && grant_id;

  assign op_err = (op_q >= 4'd10) || (((op_q == 4'd3) || (op_q == 4'd4)) && (b_q == 4'd0));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_q_d      = rsp_q_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d      = EXEC;
          a_d          = grant_id ? req1_a_i : req0_a_i;
          b_d          = grant_id ? req1_b_i : req0_b_i;
          op_d         = grant_id ? req1_op_i : req0_op_i;
          id_d         = grant_id;
          last_grant_d = grant_id;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = op_err;
        rsp_q_d     = op_err ? 4'd0 : alu_q;
        rsp_flags_d = op_err ? 4'b0100 : {alu_n, alu_z, alu_v, alu_c};
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      op_q         <= 4'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_q_q      <= 4'd0;
      rsp_flags_q  <= 4'd0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q_q      <= rsp_q_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_q_o     = rsp_q_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o   = rsp_err_q;
  assign op_count_o  = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin, error cases, back-pressure, reset, counter wrap.

module tb_alu_arbiter;
  logic       clk, rst_n;
  logic       v0, v1, rdy0, rdy1;
  logic [3:0] a0, b0, op0, a1, b1, op1;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [3:0] rsp_q, rsp_flags;
  logic [7:0] cnt;
  int         n_chk, n_fail;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(v0), .req1_valid_i(v1),
    .req0_ready_o(rdy0), .req1_ready_o(rdy1),
    .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1),
    .req0_op_i(op0), .req1_op_i(op1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_q_o(rsp_q), .rsp_flags_o(rsp_flags),
    .rsp_err_o(rsp_err), .op_count_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one op, waits for the grant, then checks EXEC and RESP timing.
  task automatic issue(input logic who, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op);
    bit ok;
    @(negedge clk);
    if (who) begin a1 = a; b1 = b; op1 = op; v1 = 1'b1; end
    else     begin a0 = a; b0 = b; op0 = op; v0 = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (who ? rdy1 : rdy0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", int'(ok), 1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);
    chk("exec_no_valid", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk("rsp_latency", int'(rsp_valid), 1);
  endtask

  task automatic expect_rsp(input string tag, input int id, input int q, input int fl, input int er);
    chk({tag, "_id"}, int'(rsp_id), id);
    chk({tag, "_q"}, int'(rsp_q), q);
    chk({tag, "_flags"}, int'(rsp_flags), fl);
    chk({tag, "_err"}, int'(rsp_err), er);
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", int'(rsp_valid), 0);
  endtask

  int   got_id[4];
  int   got_q[4];
  int   n_got;
  int   base_cnt;
  int   exp_id[4];

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; v0 = 1'b1; v1 = 1'b0; rsp_ready = 1'b0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    #12;
    chk("rst_rdy0", int'(rdy0), 0);
    chk("rst_rdy1", int'(rdy1), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_q", int'(rsp_q), 0);
    chk("rst_flags", int'(rsp_flags), 0);
    chk("rst_err", int'(rsp_err), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_cnt", int'(cnt), 0);
    v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters always valid, consumer always ready.
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 0};
`else
    exp_id = '{0, 1, 0, 1};
`endif
    @(negedge clk);
    a0 = 4'b0001; b0 = 4'b0001; op0 = 4'b0000;
    a1 = 4'b1101; b1 = 4'b1010; op1 = 4'b0111;
    v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
    n_got = 0;
    for (int i = 0; i < 30 && n_got < 4; i++) begin
      #1;
      if (rdy0 && rdy1) chk("both_ready", 1, 0);
      if (rsp_valid) begin
        got_id[n_got] = int'(rsp_id);
        got_q[n_got]  = int'(rsp_q);
        n_got++;
        if (n_got == 4) begin v0 = 1'b0; v1 = 1'b0; end
      end
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    chk("rr_count", n_got, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", got_id[i], exp_id[i]);
      chk("rr_q", got_q[i], (exp_id[i] == 0) ? 'h2 : 'h7);
    end
    chk("rr_opcount", int'(cnt), 4);

    issue(0, 4'b0100, 4'b0011, 4'b0000);
    expect_rsp("add", 0, 'h7, 'h0, 0);
    consume();
    chk("add_cnt", int'(cnt), 5);

    issue(1, 4'b0111, 4'b0001, 4'b0000);
    expect_rsp("add_ovf", 1, 'h8, 'b1010, 0);
    consume();
    issue(0, 4'b0000, 4'b0001, 4'b0001);
    expect_rsp("sub_borrow", 0, 'hf, 'b1001, 0);
    consume();
    issue(0, 4'b0101, 4'b0100, 4'b0010);
    expect_rsp("mul", 0, 'h4, 'b0001, 0);
    consume();
    issue(1, 4'b0111, 4'b0011, 4'b0100);
    expect_rsp("mod", 1, 'h1, 'h0, 0);
    consume();

    issue(1, 4'b1000, 4'b0000, 4'b0011);
    expect_rsp("div0", 1, 'h0, 'b0100, 1);
    consume();
    issue(1, 4'b1000, 4'b0010, 4'b0011);
    expect_rsp("div", 1, 'h4, 'h0, 0);
    consume();

    // Back-pressure: response must hold while both requesters wait.
    issue(0, 4'b1101, 4'b0010, 4'b1001);
    base_cnt = int'(cnt);
    v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_q", int'(rsp_q), 'h3);
      chk("hold_rdy0", int'(rdy0), 0);
      chk("hold_rdy1", int'(rdy1), 0);
    end
    v0 = 1'b0; v1 = 1'b0;
    consume();
    chk("hold_cnt", int'(cnt), (base_cnt + 1) % 256);

    // Reset while in EXEC.
    @(negedge clk);
    a0 = 4'b0011; b0 = 4'b0011; op0 = 4'b0000; v0 = 1'b1;
    #1;
    chk("pre_rst_accept", int'(rdy0), 1);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_q", int'(rsp_q), 0);
    chk("mid_rst_flags", int'(rsp_flags), 0);
    chk("mid_rst_cnt", int'(cnt), 0);
    chk("mid_rst_id", int'(rsp_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", int'(rsp_valid), 0);
    issue(0, 4'b0010, 4'b0011, 4'b0000);
    expect_rsp("post_rst", 0, 'h5, 'h0, 0);
    consume();
    chk("post_rst_cnt", int'(cnt), 1);

    // Counter wrap: 1 + 254 = 255, then one more wraps to 0.
    for (int i = 0; i < 254; i++) begin
      issue(0, 4'(i), 4'b0000, 4'b0110);
      consume();
    end
    chk("cnt_255", int'(cnt), 255);
    issue(0, 4'b1010, 4'b0101, 4'b0110);
    expect_rsp("or", 0, 'hf, 'b1000, 0);
    consume();
    chk("cnt_wrap", int'(cnt), 0);

    issue(1, 4'b0011, 4'b0001, 4'b1100);
    expect_rsp("illegal", 1, 'h0, 'b0100, 1);
    consume();
    chk("cnt_after_wrap", int'(cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
